// File: rtl/timer_setter_if.sv
// Operator-side load interface of the countdown timer: raw push-buttons in,
// preset/control levels out. The design is the slave; the button side is the master.
interface timer_setter_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic        btn_start;
  logic [16:0] sec;
  logic        set;
  logic [1:0]  field;
  logic        running;

  modport master (
    output btn_up, btn_down, btn_sel, btn_start,
    input  sec, set, field, running
  );

  modport slave (
    input  btn_up, btn_down, btn_sel, btn_start,
    output sec, set, field, running
  );
endinterface

// File: rtl/timer_setter.sv
// Debounces four buttons, edits a minutes:seconds preset, and drives the
// countdown timer's load interface (set/sec) until START commits the preset.
module timer_setter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter int DEFAULT_MIN     = 5,
  parameter int DEFAULT_SEC     = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  timer_setter_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] S_EDIT_MIN = 2'd0;
  localparam logic [1:0] S_EDIT_SEC = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;

  // Button index: 0 up, 1 down, 2 sel, 3 start.
  logic [3:0]      w_raw;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_db;
  logic [3:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [RP_W-1:0] r_rep_cnt [2];
  logic [1:0]      r_rep;

  assign w_raw = {bus.btn_start, bus.btn_sel, bus.btn_down, bus.btn_up};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      r_rep   <= '0;
      // NOTE: these arrays are small counters, not storage, so every element is reset.
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
            r_press[i]  <= r_sync2[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
      // Auto-repeat fires REPEAT_CYCLES after the press pulse, then periodically.
      for (int j = 0; j < 2; j++) begin
        r_rep[j] <= 1'b0;
        if (r_db[j]) begin
          if (r_rep_cnt[j] == RP_LAST) begin
            r_rep_cnt[j] <= '0;
            r_rep[j]     <= 1'b1;
          end else begin
            r_rep_cnt[j] <= r_rep_cnt[j] + 1'b1;
          end
        end else begin
          r_rep_cnt[j] <= '0;
        end
      end
    end
  end

  logic w_up;
  logic w_down;
  logic w_sel;
  logic w_start;
  logic w_nonzero;

  assign w_up      = r_press[0] | r_rep[0];
  assign w_down    = r_press[1] | r_rep[1];
  assign w_sel     = r_press[2];
  assign w_start   = r_press[3];

  logic [1:0] r_state;
  logic [6:0] r_min;
  logic [5:0] r_s;

  assign w_nonzero = (r_min != 7'd0) || (r_s != 6'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EDIT_MIN;
      r_min   <= 7'(DEFAULT_MIN);
      r_s     <= 6'(DEFAULT_SEC);
    end else if (r_state != S_RUN) begin
      // A START with a zero preset still consumes the cycle's events.
      if (w_start) begin
        if (w_nonzero) r_state <= S_RUN;
      end else if (w_sel) begin
        r_state <= (r_state == S_EDIT_MIN) ? S_EDIT_SEC : S_EDIT_MIN;
      end else if (w_up ^ w_down) begin
        if (r_state == S_EDIT_MIN) begin
          if (w_up) r_min <= (r_min == 7'd99) ? 7'd0 : r_min + 7'd1;
          else      r_min <= (r_min == 7'd0) ? 7'd99 : r_min - 7'd1;
        end else begin
          if (w_up) r_s <= (r_s == 6'd59) ? 6'd0 : r_s + 6'd1;
          else      r_s <= (r_s == 6'd0) ? 6'd59 : r_s - 6'd1;
        end
      end
    end
  end

  logic [16:0] r_sec;
  logic        r_set;
  logic [1:0]  r_field;
  logic        r_running;

  // min/s never change in RUN, so sec stays frozen at the committed preset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sec     <= 17'(DEFAULT_MIN * 60 + DEFAULT_SEC);
      r_set     <= 1'b1;
      r_field   <= 2'b01;
      r_running <= 1'b0;
    end else begin
      r_sec     <= 17'(r_min) * 17'd60 + 17'(r_s);
      r_set     <= (r_state != S_RUN);
      r_running <= (r_state == S_RUN);
      case (r_state)
        S_EDIT_MIN: r_field <= 2'b01;
        S_EDIT_SEC: r_field <= 2'b10;
        default:    r_field <= 2'b00;
      endcase
    end
  end

  assign bus.sec     = r_sec;
  assign bus.set     = r_set;
  assign bus.field   = r_field;
  assign bus.running = r_running;

endmodule

// File: tb/tb_timer_setter.sv
// Bench for timer_setter: hand-computed vector table plus randomized button
// activity checked every cycle against a sample-window/modular-arithmetic model.
module tb_timer_setter;
  localparam int D = 4;
  localparam int R = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_setter_if bus ();

  timer_setter #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .DEFAULT_MIN    (5),
    .DEFAULT_SEC    (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;
  bit checking = 1'b0;

  typedef struct {
    int mn;
    int sc;
    int mode;  // 0 editing minutes, 1 editing seconds, 2 running
  } mstate_t;

  logic [D:0] hist [4];
  logic       m_db [4];
  int         m_press_t [4];
  mstate_t    st [3];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic mstate_t default_state();
    mstate_t s;
    s.mn = 5; s.sc = 0; s.mode = 0;
    return s;
  endfunction

  function automatic mstate_t apply(input mstate_t s, input logic [3:0] ev);
    mstate_t n = s;
    int delta;
    if (s.mode == 2) return n;
    if (ev[3]) begin
      if (s.mn * 60 + s.sc != 0) n.mode = 2;
    end else if (ev[2]) begin
      n.mode = 1 - s.mode;
    end else if (ev[0] != ev[1]) begin
      delta = ev[0] ? 1 : -1;
      if (s.mode == 0) n.mn = (s.mn + delta + 100) % 100;
      else             n.sc = (s.sc + delta + 60) % 60;
    end
    return n;
  endfunction

  // A debounced level flips once the last D synchronised samples all disagree with it.
  task automatic model_edge(input logic [3:0] raw, input logic rst);
    logic [3:0] ev;
    logic db_pre;
    bit flip;
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        hist[b] = '0;
        m_db[b] = 1'b0;
        m_press_t[b] = 0;
      end
      for (int k = 0; k < 3; k++) st[k] = default_state();
      return;
    end
    ev = '0;
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[b][k] == m_db[b]) flip = 1'b0;
      db_pre = m_db[b];
      if (flip) begin
        m_db[b] = ~m_db[b];
        if (m_db[b]) begin
          ev[b] = 1'b1;
          m_press_t[b] = t;
        end
      end
      if (b < 2 && db_pre && t > m_press_t[b] && (t - m_press_t[b]) % R == 0) ev[b] = 1'b1;
      hist[b] = {hist[b][D-1:0], raw[b]};
    end
    st[2] = st[1];
    st[1] = st[0];
    st[0] = apply(st[0], ev);
  endtask

  function automatic logic [20:0] pack_exp(input mstate_t s);
    logic [16:0] sec_v;
    logic [1:0]  fld;
    sec_v = 17'(s.mn * 60 + s.sc);
    fld   = (s.mode == 0) ? 2'b01 : (s.mode == 1) ? 2'b10 : 2'b00;
    return {sec_v, s.mode != 2, fld, s.mode == 2};
  endfunction

  task automatic step(input logic [3:0] btn, input logic rst);
    logic [20:0] act;
    rst_n         = rst;
    bus.btn_up    = btn[0];
    bus.btn_down  = btn[1];
    bus.btn_sel   = btn[2];
    bus.btn_start = btn[3];
    @(posedge clk);
    model_edge(btn, rst);
    t++;
    @(negedge clk);
    if (checking) begin
      act = {bus.sec, bus.set, bus.field, bus.running};
      check("model_out", int'(act), int'(pack_exp(st[2])));
    end
  endtask

  typedef struct {
    logic [3:0] btn;   // {start, sel, down, up}
    logic       rst;   // 1 = hold reset instead of pressing
    int         hold;
    int         exp_sec;
    logic       exp_set;
    logic [1:0] exp_field;
    logic       exp_run;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] btn, input logic rst, input int hold,
                              input int es, input logic eset, input logic [1:0] ef,
                              input logic er);
    vec_t v;
    v.btn = btn; v.rst = rst; v.hold = hold;
    v.exp_sec = es; v.exp_set = eset; v.exp_field = ef; v.exp_run = er;
    return v;
  endfunction

  initial begin
    logic [3:0] b;
    int hold;
    vecs[0]  = mk(4'b0000, 1'b1,  4,  300, 1'b1, 2'b01, 1'b0);
    vecs[1]  = mk(4'b0001, 1'b0,  2,  300, 1'b1, 2'b01, 1'b0);
    vecs[2]  = mk(4'b0001, 1'b0, 10,  360, 1'b1, 2'b01, 1'b0);
    vecs[3]  = mk(4'b0100, 1'b0, 10,  360, 1'b1, 2'b10, 1'b0);
    vecs[4]  = mk(4'b0010, 1'b0, 10,  419, 1'b1, 2'b10, 1'b0);
    vecs[5]  = mk(4'b0011, 1'b0, 10,  419, 1'b1, 2'b10, 1'b0);
    vecs[6]  = mk(4'b0001, 1'b0, 10,  360, 1'b1, 2'b10, 1'b0);
    vecs[7]  = mk(4'b0100, 1'b0, 10,  360, 1'b1, 2'b01, 1'b0);
    vecs[8]  = mk(4'b0010, 1'b0, 70,  120, 1'b1, 2'b01, 1'b0);
    vecs[9]  = mk(4'b0000, 1'b1,  3,  300, 1'b1, 2'b01, 1'b0);
    vecs[10] = mk(4'b0010, 1'b0, 90,    0, 1'b1, 2'b01, 1'b0);
    vecs[11] = mk(4'b1000, 1'b0, 10,    0, 1'b1, 2'b01, 1'b0);
    vecs[12] = mk(4'b0010, 1'b0, 10, 5940, 1'b1, 2'b01, 1'b0);
    vecs[13] = mk(4'b0001, 1'b0, 10,    0, 1'b1, 2'b01, 1'b0);
    vecs[14] = mk(4'b0001, 1'b0, 10,   60, 1'b1, 2'b01, 1'b0);
    vecs[15] = mk(4'b0100, 1'b0, 10,   60, 1'b1, 2'b10, 1'b0);
    vecs[16] = mk(4'b0010, 1'b0, 10,  119, 1'b1, 2'b10, 1'b0);
    vecs[17] = mk(4'b1000, 1'b0, 10,  119, 1'b0, 2'b00, 1'b1);
    vecs[18] = mk(4'b0001, 1'b0, 10,  119, 1'b0, 2'b00, 1'b1);
    vecs[19] = mk(4'b0100, 1'b0, 10,  119, 1'b0, 2'b00, 1'b1);
    vecs[20] = mk(4'b0000, 1'b1,  2,  300, 1'b1, 2'b01, 1'b0);

    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_sel = 1'b0; bus.btn_start = 1'b0;
    @(negedge clk);
    checking = 1'b1;
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

    for (int i = 0; i < 21; i++) begin
      for (int c = 0; c < vecs[i].hold; c++)
        step(vecs[i].rst ? 4'b0000 : vecs[i].btn, !vecs[i].rst);
      for (int c = 0; c < 12; c++) step(4'b0000, 1'b1);
      check($sformatf("v%0d_sec", i),     int'(bus.sec),     vecs[i].exp_sec);
      check($sformatf("v%0d_set", i),     int'(bus.set),     int'(vecs[i].exp_set));
      check($sformatf("v%0d_field", i),   int'(bus.field),   int'(vecs[i].exp_field));
      check($sformatf("v%0d_running", i), int'(bus.running), int'(vecs[i].exp_run));
    end

    // Random button activity with bounce and occasional resets, model-checked each cycle.
    for (int seg = 0; seg < 60; seg++) begin
      b = 4'($urandom);
      if ($urandom_range(0, 7) != 0) b[3] = 1'b0;
      if ($urandom_range(0, 14) == 0)
        for (int c = 0; c < 2; c++) step(4'b0000, 1'b0);
      hold = $urandom_range(1, 45);
      for (int c = 0; c < hold; c++)
        step(($urandom_range(0, 9) == 0) ? 4'b0000 : b, 1'b1);
      hold = $urandom_range(0, 10);
      for (int c = 0; c < hold; c++) step(4'b0000, 1'b1);
    end
    for (int c = 0; c < 15; c++) step(4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
